// File: rtl/csr_trap_if.sv
// Retirement-side bus between the execute/writeback stage and the CSR/trap unit.
// The master drives the retiring instruction; the slave returns CSR state and redirects.
interface csr_trap_if #(
  parameter int unsigned XLEN = 64
);
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] csr_rdata;
  logic            illegal_csr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            is_break;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;

  modport master (
    output inst_valid, inst, pc, rs1_data,
    input  csr_rdata, illegal_csr, redirect_valid, redirect_pc,
    input  is_break, mepc, mcause, mstatus, mtvec
  );

  modport slave (
    input  inst_valid, inst, pc, rs1_data,
    output csr_rdata, illegal_csr, redirect_valid, redirect_pc,
    output is_break, mepc, mcause, mstatus, mtvec
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: retires SYSTEM instructions,
// redirects on ecall/mret and latches a sticky halt on ebreak.
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
  parameter logic [XLEN-1:0] MTVEC_RST   = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  csr_trap_if.slave    bus
);

  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h88);
  localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(64'd11);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;

  logic [XLEN-1:0] csr_rdata_c;
  logic            illegal_csr_c;
  logic            redirect_valid_c;
  logic [XLEN-1:0] redirect_pc_c;

  logic            active;
  logic [2:0]      funct3;
  logic [11:0]     addr;
  logic [4:0]      zimm;
  logic            is_ecall, is_ebreak, is_mret, is_priv, is_csr_op;
  logic            addr_ok, do_write;
  logic [XLEN-1:0] src, old_val, new_val;

  // State and CSR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Decode, next-state and combinational outputs
  always_comb begin
    state_d          = state_q;
    mstatus_d        = mstatus_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mcycle_d         = mcycle_q;
    minstret_d       = minstret_q;
    csr_rdata_c      = '0;
    illegal_csr_c    = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;
    old_val          = '0;
    addr_ok          = 1'b1;

    active    = bus.inst_valid && (state_q == RUN) && (bus.inst[6:0] == OPC_SYSTEM);
    funct3    = bus.inst[14:12];
    addr      = bus.inst[31:20];
    zimm      = bus.inst[19:15];
    is_ecall  = (bus.inst == INST_ECALL);
    is_ebreak = (bus.inst == INST_EBREAK);
    is_mret   = (bus.inst == INST_MRET);
    is_priv   = (funct3 == 3'b000);
    is_csr_op = (funct3[1:0] != 2'b00);
    src       = funct3[2] ? XLEN'(zimm) : bus.rs1_data;

    case (addr)
      ADDR_MSTATUS:  old_val = mstatus_q;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MCYCLE:   old_val = mcycle_q;
      ADDR_MINSTRET: old_val = minstret_q;
      default:       addr_ok = 1'b0;
    endcase

    case (funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase

    // Set/clear with a zero rs1/uimm field is a pure read
    do_write = active && is_csr_op && addr_ok && !(funct3[1] && (zimm == 5'd0));

    if (state_q == RUN) begin
      mcycle_d = mcycle_q + XLEN'(1);
      if (bus.inst_valid) minstret_d = minstret_q + XLEN'(1);
    end

    if (active) begin
      if (is_priv) begin
        illegal_csr_c = !(is_ecall || is_ebreak || is_mret);
        if (is_ecall) begin
          redirect_valid_c    = 1'b1;
          redirect_pc_c       = {mtvec_q[XLEN-1:2], 2'b00};
          mepc_d              = bus.pc;
          mcause_d            = CAUSE_ECALL_M;
          mstatus_d[MPIE_BIT] = mstatus_q[MIE_BIT];
          mstatus_d[MIE_BIT]  = 1'b0;
        end else if (is_mret) begin
          redirect_valid_c    = 1'b1;
          redirect_pc_c       = mepc_q;
          mstatus_d[MIE_BIT]  = mstatus_q[MPIE_BIT];
          mstatus_d[MPIE_BIT] = 1'b1;
        end else if (is_ebreak) begin
          state_d = HALT;
        end
      end else if (!is_csr_op) begin
        illegal_csr_c = 1'b1;
      end else begin
        illegal_csr_c = !addr_ok;
        csr_rdata_c   = old_val;
      end
    end

    // Explicit writes take priority over the counter increments above
    if (do_write) begin
      case (addr)
        ADDR_MSTATUS:  mstatus_d  = (MSTATUS_RST & ~MSTATUS_WMASK) | (new_val & MSTATUS_WMASK);
        ADDR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
        ADDR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_d   = new_val;
        ADDR_MCYCLE:   mcycle_d   = new_val;
        ADDR_MINSTRET: minstret_d = new_val;
        default:       ;
      endcase
    end
  end

  assign bus.csr_rdata      = csr_rdata_c;
  assign bus.illegal_csr    = illegal_csr_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;
  assign bus.is_break       = (state_q == HALT);
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.mstatus        = mstatus_q;
  assign bus.mtvec          = mtvec_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: one instruction per cycle driven on the
// falling edge, combinational outputs checked mid-cycle, registered ones a cycle later.
module tb_csr_trap_unit;

  localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [31:0] RD_MCYCLE    = 32'hB000_22F3; // csrrs x5, mcycle, x0
  localparam logic [31:0] RD_MINSTRET  = 32'hB020_22F3; // csrrs x5, minstret, x0
  localparam logic [31:0] RD_MSTATUS   = 32'h3000_22F3; // csrrs x5, mstatus, x0
  localparam logic [31:0] RD_BAD       = 32'h7C00_22F3; // csrrs x5, 0x7C0, x0
  localparam logic [31:0] WR_MTVEC     = 32'h3050_9073; // csrrw x0, mtvec, x1
  localparam logic [31:0] WR_MEPC      = 32'h3410_9073; // csrrw x0, mepc, x1
  localparam logic [31:0] WR_MCYCLE    = 32'hB000_9073; // csrrw x0, mcycle, x1
  localparam logic [31:0] WR_MSTATUS   = 32'h3000_9073; // csrrw x0, mstatus, x1
  localparam logic [31:0] WRI_MINSTRET = 32'hB022_D073; // csrrwi x0, minstret, 5
  localparam logic [31:0] SETI_MIE     = 32'h3004_6073; // csrrsi x0, mstatus, 8
  localparam logic [31:0] CLRI_MIE     = 32'h3004_7073; // csrrci x0, mstatus, 8
  localparam logic [31:0] F3_4         = 32'h3000_C073; // reserved funct3=100
  localparam logic [31:0] WFI          = 32'h1050_0073;
  localparam logic [31:0] ADDI         = 32'h0000_0013;
  localparam logic [31:0] ECALL        = 32'h0000_0073;
  localparam logic [31:0] EBREAK       = 32'h0010_0073;
  localparam logic [31:0] MRET         = 32'h3020_0073;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  csr_trap_if #(.XLEN(64)) bus ();

  csr_trap_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] r);
    @(negedge clk);
    bus.inst_valid = v;
    bus.inst       = i;
    bus.pc         = p;
    bus.rs1_data   = r;
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    bus.pc         = '0;
    bus.rs1_data   = '0;
    #12;
    chk("rst_mstatus", bus.mstatus, MST_RST);
    chk("rst_mtvec", 64'(bus.mtvec), 64'h0);
    chk("rst_mepc", bus.mepc, 64'h0);
    chk("rst_mcause", bus.mcause, 64'h0);
    chk("rst_is_break", 64'(bus.is_break), 64'h0);
    chk("rst_rdata", bus.csr_rdata, 64'h0);
    chk("rst_redirect", 64'(bus.redirect_valid), 64'h0);
    chk("rst_illegal", 64'(bus.illegal_csr), 64'h0);

    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    drive(1'b1, RD_MCYCLE, 64'h0, 64'h0);                      // k10
    chk("idle_mcycle", bus.csr_rdata, 64'd10);
    chk("idle_mcycle_legal", 64'(bus.illegal_csr), 64'h0);
    drive(1'b1, RD_MINSTRET, 64'h0, 64'h0);                    // k11
    chk("idle_minstret", bus.csr_rdata, 64'd1);
    chk("idle_mstatus", bus.mstatus, MST_RST);
    chk("idle_is_break", 64'(bus.is_break), 64'h0);

    drive(1'b1, WR_MTVEC, 64'h0, 64'h8000_0103);               // k12
    chk("mtvec_old", bus.csr_rdata, 64'h0);
    drive(1'b0, 32'h0, 64'h0, 64'h0);                          // k13
    chk("mtvec_new", bus.mtvec, 64'h8000_0100);
    chk("idle_rdata_zero", bus.csr_rdata, 64'h0);

    drive(1'b1, SETI_MIE, 64'h0, 64'h0);                       // k14
    chk("setmie_old", bus.csr_rdata, MST_RST);
    drive(1'b1, ECALL, 64'h8000_0040, 64'h0);                  // k15
    chk("ecall_mstatus_pre", bus.mstatus, 64'h0000_000a_0000_1808);
    chk("ecall_redir_v", 64'(bus.redirect_valid), 64'h1);
    chk("ecall_redir_pc", bus.redirect_pc, 64'h8000_0100);
    chk("ecall_legal", 64'(bus.illegal_csr), 64'h0);
    drive(1'b0, 32'h0, 64'h0, 64'h0);                          // k16
    chk("ecall_mepc", bus.mepc, 64'h8000_0040);
    chk("ecall_mcause", bus.mcause, 64'd11);
    chk("ecall_mstatus", bus.mstatus, 64'h0000_000a_0000_1880);
    chk("idle_redirect", 64'(bus.redirect_valid), 64'h0);

    drive(1'b1, WR_MEPC, 64'h0, 64'h8000_0044);                // k17
    chk("mepc_old", bus.csr_rdata, 64'h8000_0040);
    drive(1'b1, MRET, 64'h0, 64'h0);                           // k18
    chk("mret_redir_v", 64'(bus.redirect_valid), 64'h1);
    chk("mret_redir_pc", bus.redirect_pc, 64'h8000_0044);
    drive(1'b0, 32'h0, 64'h0, 64'h0);                          // k19
    chk("mret_mstatus", bus.mstatus, 64'h0000_000a_0000_1888);
    chk("mret_mepc", bus.mepc, 64'h8000_0044);

    drive(1'b1, RD_BAD, 64'h0, 64'h0);                         // k20
    chk("bad_illegal", 64'(bus.illegal_csr), 64'h1);
    chk("bad_rdata", bus.csr_rdata, 64'h0);
    chk("bad_redirect", 64'(bus.redirect_valid), 64'h0);
    drive(1'b1, RD_MSTATUS, 64'h0, 64'h0);                     // k21
    chk("rd_mstatus", bus.csr_rdata, 64'h0000_000a_0000_1888);
    chk("rd_mstatus_legal", 64'(bus.illegal_csr), 64'h0);
    drive(1'b1, RD_MINSTRET, 64'h0, 64'h0);                    // k22
    chk("minstret_count", bus.csr_rdata, 64'd9);
    chk("rd_mstatus_nowrite", bus.mstatus, 64'h0000_000a_0000_1888);

    drive(1'b1, RD_MCYCLE, 64'h0, 64'h0);                      // k23
    chk("mcycle_23", bus.csr_rdata, 64'd23);
    drive(1'b1, RD_MCYCLE, 64'h0, 64'h0);                      // k24
    chk("mcycle_24_no_wr", bus.csr_rdata, 64'd24);
    drive(1'b1, WR_MCYCLE, 64'h0, ONES);                       // k25
    chk("mcycle_wr_old", bus.csr_rdata, 64'd25);
    drive(1'b1, RD_MCYCLE, 64'h0, 64'h0);                      // k26
    chk("mcycle_wr_wins", bus.csr_rdata, ONES);
    drive(1'b1, RD_MCYCLE, 64'h0, 64'h0);                      // k27
    chk("mcycle_wrap", bus.csr_rdata, 64'h0);

    drive(1'b1, WRI_MINSTRET, 64'h0, 64'h0);                   // k28
    chk("minstret_wr_old", bus.csr_rdata, 64'd15);
    drive(1'b1, RD_MINSTRET, 64'h0, 64'h0);                    // k29
    chk("minstret_wr_wins", bus.csr_rdata, 64'd5);

    drive(1'b1, CLRI_MIE, 64'h0, 64'h0);                       // k30
    chk("clrmie_old", bus.csr_rdata, 64'h0000_000a_0000_1888);
    drive(1'b1, WR_MSTATUS, 64'h0, ONES);                      // k31
    chk("clrmie_new", bus.mstatus, 64'h0000_000a_0000_1880);
    drive(1'b1, F3_4, 64'h0, 64'h0);                           // k32
    chk("mstatus_mask", bus.mstatus, 64'h0000_000a_0000_1888);
    chk("f3_4_illegal", 64'(bus.illegal_csr), 64'h1);
    drive(1'b1, WFI, 64'h0, 64'h0);                            // k33
    chk("wfi_illegal", 64'(bus.illegal_csr), 64'h1);
    chk("wfi_redirect", 64'(bus.redirect_valid), 64'h0);
    drive(1'b1, ADDI, 64'h0, 64'h0);                           // k34
    chk("addi_legal", 64'(bus.illegal_csr), 64'h0);
    chk("addi_rdata", bus.csr_rdata, 64'h0);

    drive(1'b1, EBREAK, 64'h0, 64'h0);                         // k35
    chk("ebreak_same_cycle", 64'(bus.is_break), 64'h0);
    chk("ebreak_legal", 64'(bus.illegal_csr), 64'h0);
    drive(1'b1, WR_MTVEC, 64'h0, 64'h1234);                    // k36
    chk("halt_is_break", 64'(bus.is_break), 64'h1);
    chk("halt_illegal", 64'(bus.illegal_csr), 64'h0);
    chk("halt_rdata", bus.csr_rdata, 64'h0);
    chk("halt_redirect", 64'(bus.redirect_valid), 64'h0);
    drive(1'b1, ECALL, 64'h8000_0080, 64'h0);                  // k37
    chk("halt_mtvec", bus.mtvec, 64'h8000_0100);
    chk("halt_sticky", 64'(bus.is_break), 64'h1);
    chk("halt_ecall_noredir", 64'(bus.redirect_valid), 64'h0);
    drive(1'b0, 32'h0, 64'h0, 64'h0);
    chk("halt_mepc", bus.mepc, 64'h8000_0044);

    rst = 1'b1;
    #1;
    chk("arst_is_break", 64'(bus.is_break), 64'h0);
    chk("arst_mtvec", bus.mtvec, 64'h0);
    chk("arst_mstatus", bus.mstatus, MST_RST);
    chk("arst_mepc", bus.mepc, 64'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
